// File: rtl/bsg_cache_sbuf_pkg.sv
// Shared definitions for the two-entry cache store buffer.
package bsg_cache_sbuf_pkg;

    localparam int sbuf_els_lp = 2;

    typedef enum logic [1:0] {
        e_sbuf_empty = 2'd0,
        e_sbuf_one   = 2'd1,
        e_sbuf_full  = 2'd2
    } sbuf_count_e;

    function automatic int sbuf_mask_width(input int data_width);
        return data_width / 8;
    endfunction

    // Entries are packed as {addr, data, mask}.
    function automatic int sbuf_entry_width(input int addr_width, input int data_width);
        return addr_width + data_width + (data_width / 8);
    endfunction

endpackage

// File: rtl/bsg_cache_sbuf_ctrl_chk.sv
// Protocol checker for the store buffer drain interface.
module bsg_cache_sbuf_ctrl_chk (
    input logic clk_i,
    input logic reset_i,
    input logic yumi_i,
    input logic v_o
);
    // Consuming the head while nothing is valid is a protocol violation.
    assert property (@(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_o))
        else $error("sbuf: yumi_i asserted without v_o");

endmodule

// File: rtl/bsg_cache_sbuf_el_queue.sv
// Two-entry store buffer datapath: el0/el1 registers, el1 refill mux, head mux.
module bsg_cache_sbuf_el_queue #(
    parameter int entry_width_p = 32
) (
    input  logic                     clk_i,
    input  logic                     el0_en_i,
    input  logic                     el1_en_i,
    input  logic                     el1_sel_in_i,
    input  logic                     head_sel_in_i,
    input  logic [entry_width_p-1:0] in_i,
    output logic [entry_width_p-1:0] head_o,
    output logic [entry_width_p-1:0] el0_o,
    output logic [entry_width_p-1:0] el1_o
);
    import bsg_cache_sbuf_pkg::*;

    logic [entry_width_p-1:0] el0_r;
    logic [entry_width_p-1:0] el1_r;
    logic [entry_width_p-1:0] el1_n_s;

    assign el1_n_s = el1_sel_in_i ? in_i : el0_r;

    // Entry storage; deliberately not reset, validity is tracked by the controller.
    always_ff @(posedge clk_i) begin
        if (el0_en_i) el0_r <= in_i;
        else          el0_r <= el0_r;
        if (el1_en_i) el1_r <= el1_n_s;
        else          el1_r <= el1_r;
    end

    assign head_o = head_sel_in_i ? in_i : el1_r;
    assign el0_o  = el0_r;
    assign el1_o  = el1_r;

endmodule

// File: rtl/bsg_cache_sbuf_ctrl.sv
// Two-entry in-order store buffer controller with optional load bypass lookup.
// Define BSG_CACHE_SBUF_BYPASS_EN to compile in the bypass comparators.
module bsg_cache_sbuf_ctrl
    import bsg_cache_sbuf_pkg::*;
#(
    parameter  int data_width_p  = 16,
    parameter  int addr_width_p  = 8,
    localparam int mask_width_lp = data_width_p / 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     v_i,
    input  logic [addr_width_p-1:0]  addr_i,
    input  logic [data_width_p-1:0]  data_i,
    input  logic [mask_width_lp-1:0] mask_i,
    output logic                     ready_o,
    output logic                     v_o,
    output logic [addr_width_p-1:0]  addr_o,
    output logic [data_width_p-1:0]  data_o,
    output logic [mask_width_lp-1:0] mask_o,
    input  logic                     yumi_i,
    output logic                     empty_o,
    output logic                     full_o,
    input  logic [addr_width_p-1:0]  bypass_addr_i,
    output logic [data_width_p-1:0]  bypass_data_o,
    output logic [mask_width_lp-1:0] bypass_mask_o
);
    localparam int entry_w_lp = sbuf_entry_width(addr_width_p, data_width_p);

    sbuf_count_e count_r, count_n_s;
    logic ready_s, v_s, enq_s, deq_s;
    logic el0_en_s, el1_en_s, el1_sel_in_s, head_sel_in_s;
    logic [entry_w_lp-1:0] in_s, head_s, el0_s, el1_s;

    assign in_s  = {addr_i, data_i, mask_i};
    assign enq_s = v_i & ready_s;
    // A yumi without a valid head must not disturb state.
    assign deq_s = yumi_i & v_s;

    // Occupancy register.
    always_ff @(posedge clk_i) begin
        if (reset_i) count_r <= e_sbuf_empty;
        else         count_r <= count_n_s;
    end

    // Next occupancy and entry load controls.
    always_comb begin
        count_n_s    = count_r;
        el0_en_s     = 1'b0;
        el1_en_s     = 1'b0;
        el1_sel_in_s = 1'b1;
        case (count_r)
            e_sbuf_empty: begin
                if (enq_s && !deq_s) begin
                    el1_en_s  = 1'b1;
                    count_n_s = e_sbuf_one;
                end else begin
                    count_n_s = e_sbuf_empty;
                end
            end
            e_sbuf_one: begin
                if (enq_s && deq_s) begin
                    el1_en_s  = 1'b1;
                    count_n_s = e_sbuf_one;
                end else if (enq_s) begin
                    el0_en_s  = 1'b1;
                    count_n_s = e_sbuf_full;
                end else if (deq_s) begin
                    count_n_s = e_sbuf_empty;
                end else begin
                    count_n_s = e_sbuf_one;
                end
            end
            e_sbuf_full: begin
                if (deq_s) begin
                    el1_en_s     = 1'b1;
                    el1_sel_in_s = 1'b0;
                    count_n_s    = e_sbuf_one;
                end else begin
                    count_n_s = e_sbuf_full;
                end
            end
            default: count_n_s = e_sbuf_empty;
        endcase
    end

    // Handshake and occupancy flags from the registered count.
    always_comb begin
        ready_s       = ~reset_i & (count_r != e_sbuf_full);
        v_s           = ~reset_i & ((count_r != e_sbuf_empty) | v_i);
        head_sel_in_s = (count_r == e_sbuf_empty);
        full_o        = (count_r == e_sbuf_full);
        empty_o       = (count_r == e_sbuf_empty);
    end

    assign ready_o = ready_s;
    assign v_o     = v_s;
    assign {addr_o, data_o, mask_o} = head_s;

    bsg_cache_sbuf_el_queue #(.entry_width_p(entry_w_lp)) el_queue (
        .clk_i         (clk_i),
        .el0_en_i      (el0_en_s),
        .el1_en_i      (el1_en_s),
        .el1_sel_in_i  (el1_sel_in_s),
        .head_sel_in_i (head_sel_in_s),
        .in_i          (in_s),
        .head_o        (head_s),
        .el0_o         (el0_s),
        .el1_o         (el1_s)
    );

    bsg_cache_sbuf_ctrl_chk chk (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .yumi_i  (yumi_i),
        .v_o     (v_s)
    );

`ifdef BSG_CACHE_SBUF_BYPASS_EN
    logic el0_hit_s, el1_hit_s;
    logic [data_width_p-1:0]  el0_data_s, el1_data_s;
    logic [mask_width_lp-1:0] el0_mask_s, el1_mask_s;

    assign el0_data_s = el0_s[mask_width_lp +: data_width_p];
    assign el1_data_s = el1_s[mask_width_lp +: data_width_p];
    assign el0_mask_s = el0_s[mask_width_lp-1:0];
    assign el1_mask_s = el1_s[mask_width_lp-1:0];
    assign el0_hit_s  = (count_r == e_sbuf_full)
                      & (el0_s[entry_w_lp-1 -: addr_width_p] == bypass_addr_i);
    assign el1_hit_s  = (count_r != e_sbuf_empty)
                      & (el1_s[entry_w_lp-1 -: addr_width_p] == bypass_addr_i);

    // Per-byte merge; el0 is the newer entry and wins over el1.
    always_comb begin
        bypass_data_o = '0;
        bypass_mask_o = '0;
        for (int b = 0; b < mask_width_lp; b++) begin
            if (reset_i) begin
                bypass_data_o[8*b +: 8] = 8'h00;
                bypass_mask_o[b]        = 1'b0;
            end else if (el0_hit_s && el0_mask_s[b]) begin
                bypass_data_o[8*b +: 8] = el0_data_s[8*b +: 8];
                bypass_mask_o[b]        = 1'b1;
            end else if (el1_hit_s && el1_mask_s[b]) begin
                bypass_data_o[8*b +: 8] = el1_data_s[8*b +: 8];
                bypass_mask_o[b]        = 1'b1;
            end else begin
                bypass_data_o[8*b +: 8] = 8'h00;
                bypass_mask_o[b]        = 1'b0;
            end
        end
    end
`else
    logic unused_bypass_s;
    assign unused_bypass_s = ^{bypass_addr_i, el0_s, el1_s};
    assign bypass_data_o   = '0;
    assign bypass_mask_o   = '0;
`endif

endmodule
